gaussian_window_sched: RTL and testbench

- Scheduler and configurator for the 3x3 fixed-point Gaussian convolution block.
- Loads the 9 kernel coefficients serially and presents them as a 3x3 matrix with a one-cycle load strobe.
- Takes a raster pixel stream, keeps two line buffers, and emits a 3x3 window plus data-valid for every interior output position.
- Sits between the pixel source and the convolution block's data/kernel inputs.

---
 rtl/gaussian_window_sched_if.sv | 30 +++
 rtl/gaussian_window_sched.sv | 166 ++++++++++++++++
 tb/tb_gaussian_window_sched.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/gaussian_window_sched_if.sv
// Handshake and data bundle between the pixel/coefficient source, the scheduler
// and the downstream 3x3 Gaussian convolution block.
interface gaussian_window_sched_if #(
    parameter int NBIT = 8
);
    logic [NBIT-1:0]             i_kernel_coef;
    logic                        i_kernel_coef_valid;
    logic                        o_kernel_coef_ready;
    logic [NBIT-1:0]             i_pixel;
    logic                        i_pixel_valid;
    logic                        o_pixel_ready;
    logic [2:0][2:0][NBIT-1:0]   o_kernel;
    logic                        o_kernel_valid;
    logic [2:0][2:0][NBIT-1:0]   o_window;
    logic                        o_window_valid;
    logic                        o_frame_done;
    logic                        o_busy;

    modport master (
        output i_kernel_coef, i_kernel_coef_valid, i_pixel, i_pixel_valid,
        input  o_kernel_coef_ready, o_pixel_ready, o_kernel, o_kernel_valid,
        input  o_window, o_window_valid, o_frame_done, o_busy
    );

    modport slave (
        input  i_kernel_coef, i_kernel_coef_valid, i_pixel, i_pixel_valid,
        output o_kernel_coef_ready, o_pixel_ready, o_kernel, o_kernel_valid,
        output o_window, o_window_valid, o_frame_done, o_busy
    );
endinterface

// File: rtl/gaussian_window_sched.sv
// Kernel loader and 3x3 sliding-window generator feeding the Gaussian convolution block.
// Coefficients are staged and committed atomically; pixels pass through two line buffers.
module gaussian_window_sched #(
    parameter int NBIT        = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int KERNEL_SIZE = 3
) (
    input logic                    i_clk,
    input logic                    i_rst,
    gaussian_window_sched_if.slave bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    if (KERNEL_SIZE != 3) begin : g_bad_kernel_size
        $error("gaussian_window_sched: only KERNEL_SIZE=3 is supported");
    end
    if (IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : g_bad_image_size
        $error("gaussian_window_sched: IMG_WIDTH and IMG_HEIGHT must be >= 3");
    end

    typedef enum logic [1:0] {IDLE, KLOAD, KCOMMIT, STREAM} state_t;

    state_t                    state;
    logic [CW-1:0]             col;
    logic [RW-1:0]             row;
    logic [3:0]                coef_idx;
    logic                      kernel_loaded;
    logic [8:0][NBIT-1:0]      stage;
    logic [2:0][2:0][NBIT-1:0] kernel;
    logic                      kernel_valid;
    logic [2:0][2:0][NBIT-1:0] window;
    logic                      window_valid;
    logic                      frame_done;

    logic [NBIT-1:0]           lb0 [IMG_WIDTH];
    logic [NBIT-1:0]           lb1 [IMG_WIDTH];
    logic [NBIT-1:0]           lb0_rd;
    logic [NBIT-1:0]           lb1_rd;

    logic                      coef_ready;
    logic                      pixel_ready;
    logic                      coef_take;
    logic                      pixel_take;

    // A pending coefficient always beats a pixel in IDLE so a reload cannot be starved.
    always_comb begin
        coef_ready  = 1'b0;
        pixel_ready = 1'b0;
        if (!i_rst) begin
            case (state)
                IDLE: begin
                    coef_ready  = 1'b1;
                    pixel_ready = kernel_loaded && !bus.i_kernel_coef_valid;
                end
                KLOAD:   coef_ready  = 1'b1;
                STREAM:  pixel_ready = 1'b1;
                default: ;
            endcase
        end
    end

    assign coef_take  = bus.i_kernel_coef_valid && coef_ready;
    assign pixel_take = bus.i_pixel_valid && pixel_ready;
    assign lb0_rd     = lb0[col];
    assign lb1_rd     = lb1[col];

    // Line buffers carry no reset; their stale contents are masked by the row/column gate.
    always_ff @(posedge i_clk) begin
        if (pixel_take) begin
            lb1[col] <= lb0_rd;
            lb0[col] <= bus.i_pixel;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            col           <= '0;
            row           <= '0;
            coef_idx      <= '0;
            kernel_loaded <= 1'b0;
            stage         <= '0;
            kernel        <= '0;
            kernel_valid  <= 1'b0;
            window        <= '0;
            window_valid  <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            kernel_valid <= 1'b0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;

            if (pixel_take) begin
                for (int i = 0; i < 3; i++) begin
                    window[i][0] <= window[i][1];
                    window[i][1] <= window[i][2];
                end
                window[0][2] <= lb1_rd;
                window[1][2] <= lb0_rd;
                window[2][2] <= bus.i_pixel;
                window_valid <= (row >= ROW_TWO) && (col >= COL_TWO);
                if (col == COL_LAST) begin
                    col <= '0;
                    if (row == ROW_LAST) begin
                        row        <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (coef_take) begin
                        stage[0] <= bus.i_kernel_coef;
                        coef_idx <= 4'd1;
                        state    <= KLOAD;
                    end else if (pixel_take) begin
                        state <= STREAM;
                    end
                end
                KLOAD: begin
                    if (coef_take) begin
                        stage[coef_idx] <= bus.i_kernel_coef;
                        if (coef_idx == 4'd8) begin
                            coef_idx <= '0;
                            state    <= KCOMMIT;
                        end else begin
                            coef_idx <= coef_idx + 4'd1;
                        end
                    end
                end
                KCOMMIT: begin
                    kernel        <= stage;
                    kernel_valid  <= 1'b1;
                    kernel_loaded <= 1'b1;
                    state         <= IDLE;
                end
                STREAM: begin
                    if (pixel_take && col == COL_LAST && row == ROW_LAST) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_kernel_coef_ready = coef_ready;
    assign bus.o_pixel_ready       = pixel_ready;
    assign bus.o_kernel            = kernel;
    assign bus.o_kernel_valid      = kernel_valid;
    assign bus.o_window            = window;
    assign bus.o_window_valid      = window_valid;
    assign bus.o_frame_done        = frame_done;
    assign bus.o_busy              = (state != IDLE);
endmodule

// File: tb/tb_gaussian_window_sched.sv
// Directed bench for gaussian_window_sched on a 4x4 image: kernel load timing,
// window contents, bubbles, arbitration, and mid-frame reset recovery.
module tb_gaussian_window_sched;
    logic clk;
    logic rst;
    int   passed;
    int   failed;
    int   total;

    gaussian_window_sched_if #(.NBIT(8)) bus ();

    gaussian_window_sched #(
        .NBIT(8),
        .IMG_WIDTH(4),
        .IMG_HEIGHT(4),
        .KERNEL_SIZE(3)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Loads k[0]..k[8]; optional one-cycle gap before gap_at, optional simultaneous pixel offer on k[0].
    task automatic load_kernel(input logic [8:0][7:0] k, input int gap_at, input bit with_pixel);
        for (int idx = 0; idx < 9; idx++) begin
            if (idx == gap_at) begin
                bus.i_kernel_coef_valid = 1'b0;
                tick();
                check_output("kv_gap", bus.o_kernel_valid, 1'b0);
            end
            bus.i_kernel_coef       = k[idx];
            bus.i_kernel_coef_valid = 1'b1;
            if (idx == 0 && with_pixel) begin
                bus.i_pixel       = 8'hA5;
                bus.i_pixel_valid = 1'b1;
            end
            #1;
            check_output("coef_ready_load", bus.o_kernel_coef_ready, 1'b1);
            if (idx == 0 && with_pixel) check_output("pix_ready_arb", bus.o_pixel_ready, 1'b0);
            tick();
            bus.i_pixel_valid = 1'b0;
            check_output("kv_early", bus.o_kernel_valid, 1'b0);
            check_output("busy_load", bus.o_busy, 1'b1);
            if (idx == 0 && with_pixel) check_output("wv_arb", bus.o_window_valid, 1'b0);
        end
        bus.i_kernel_coef_valid = 1'b0;
        tick();
        check_output("kv_strobe", bus.o_kernel_valid, 1'b1);
        check_output("kernel_commit", bus.o_kernel, k);
        tick();
        check_output("kv_one_cycle", bus.o_kernel_valid, 1'b0);
        check_output("kernel_hold", bus.o_kernel, k);
        check_output("busy_idle", bus.o_busy, 1'b0);
        check_output("pix_ready_idle", bus.o_pixel_ready, 1'b1);
    endtask

    // Streams the first npix pixels of a 4x4 frame with p = 4r+c.
    task automatic run_frame(input bit bubbles, input bit spam, input int npix);
        int r;
        int c;
        int wins;
        int nb;
        bit exp_v;
        logic [2:0][2:0][7:0] ew;
        wins = 0;
        for (int idx = 0; idx < npix; idx++) begin
            r = idx / 4;
            c = idx % 4;
            if (bubbles && (idx % 2 == 1)) begin
                nb = $urandom_range(1, 3);
                for (int b = 0; b < nb; b++) begin
                    bus.i_pixel_valid = 1'b0;
                    tick();
                    check_output("wv_bubble", bus.o_window_valid, 1'b0);
                end
            end
            bus.i_pixel             = 8'(idx);
            bus.i_pixel_valid       = 1'b1;
            bus.i_kernel_coef       = 8'd9;
            bus.i_kernel_coef_valid = spam && (idx > 0);
            #1;
            check_output("pix_ready", bus.o_pixel_ready, 1'b1);
            if (spam && idx > 0) check_output("coef_ready_stream", bus.o_kernel_coef_ready, 1'b0);
            tick();
            exp_v = (r >= 2) && (c >= 2);
            check_output("wv", bus.o_window_valid, exp_v);
            if (exp_v) begin
                wins++;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        ew[i][j] = 8'(4 * (r - 2 + i) + (c - 2 + j));
                check_output("window", bus.o_window, ew);
                check_output("frame_done", bus.o_frame_done, idx == 15);
            end else begin
                check_output("frame_done_idle", bus.o_frame_done, 1'b0);
            end
            if (idx == 0) check_output("busy_stream", bus.o_busy, 1'b1);
        end
        bus.i_pixel_valid       = 1'b0;
        bus.i_kernel_coef_valid = 1'b0;
        if (npix == 16) begin
            tick();
            check_output("wv_after_frame", bus.o_window_valid, 1'b0);
            check_output("fd_after_frame", bus.o_frame_done, 1'b0);
            check_output("busy_after_frame", bus.o_busy, 1'b0);
            check_output("window_count", 72'(wins), 72'd4);
        end
    endtask

    task automatic check_reset_outputs();
        check_output("rst_kv", bus.o_kernel_valid, 1'b0);
        check_output("rst_wv", bus.o_window_valid, 1'b0);
        check_output("rst_fd", bus.o_frame_done, 1'b0);
        check_output("rst_busy", bus.o_busy, 1'b0);
        check_output("rst_kernel", bus.o_kernel, 72'd0);
        check_output("rst_window", bus.o_window, 72'd0);
        check_output("rst_pix_ready", bus.o_pixel_ready, 1'b0);
        check_output("rst_coef_ready", bus.o_kernel_coef_ready, 1'b0);
    endtask

    logic [8:0][7:0] gauss;
    logic [8:0][7:0] ramp;

    initial begin
        passed = 0;
        failed = 0;
        total  = 0;
        gauss  = {8'd1, 8'd2, 8'd1, 8'd2, 8'd4, 8'd2, 8'd1, 8'd2, 8'd1};
        for (int i = 0; i < 9; i++) ramp[i] = 8'(9 - i);

        rst                     = 1'b1;
        bus.i_kernel_coef       = '0;
        bus.i_kernel_coef_valid = 1'b0;
        bus.i_pixel             = '0;
        bus.i_pixel_valid       = 1'b0;
        tick();
        tick();
        check_reset_outputs();
        rst = 1'b0;

        $display("[TB] pixels offered before any kernel load");
        bus.i_pixel       = 8'h55;
        bus.i_pixel_valid = 1'b1;
        #1;
        check_output("pix_ready_nokernel", bus.o_pixel_ready, 1'b0);
        check_output("coef_ready_idle", bus.o_kernel_coef_ready, 1'b1);
        for (int n = 0; n < 4; n++) begin
            tick();
            check_output("wv_nokernel", bus.o_window_valid, 1'b0);
            check_output("busy_nokernel", bus.o_busy, 1'b0);
        end
        bus.i_pixel_valid = 1'b0;

        $display("[TB] load Gaussian kernel back-to-back");
        load_kernel(gauss, -1, 1'b0);
        check_output("k11", 72'(bus.o_kernel[1][1]), 72'd4);
        check_output("k01", 72'(bus.o_kernel[0][1]), 72'd2);

        $display("[TB] continuous frame");
        run_frame(1'b0, 1'b0, 16);

        $display("[TB] frame with bubbles");
        run_frame(1'b1, 1'b0, 16);

        $display("[TB] coefficients offered while streaming");
        run_frame(1'b0, 1'b1, 16);
        check_output("kernel_unchanged", bus.o_kernel, gauss);

        $display("[TB] simultaneous coefficient and pixel in IDLE, gapped load");
        load_kernel(ramp, 4, 1'b1);
        check_output("ramp_k00", 72'(bus.o_kernel[0][0]), 72'd9);
        check_output("ramp_k02", 72'(bus.o_kernel[0][2]), 72'd7);
        check_output("ramp_k22", 72'(bus.o_kernel[2][2]), 72'd1);

        $display("[TB] reset in the middle of frame 2");
        run_frame(1'b0, 1'b0, 16);
        run_frame(1'b0, 1'b0, 10);
        rst = 1'b1;
        tick();
        check_reset_outputs();
        rst               = 1'b0;
        bus.i_pixel_valid = 1'b1;
        #1;
        check_output("pix_ready_after_rst", bus.o_pixel_ready, 1'b0);
        for (int n = 0; n < 3; n++) begin
            tick();
            check_output("fd_after_rst", bus.o_frame_done, 1'b0);
            check_output("wv_after_rst", bus.o_window_valid, 1'b0);
        end
        bus.i_pixel_valid = 1'b0;
        load_kernel(gauss, -1, 1'b0);
        run_frame(1'b0, 1'b0, 16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
